// File: rtl/ieee754_norm_arbiter.sv
// Two-port round-robin front end for a shared 48-bit leading-one normalizer.
// Two-stage valid/ready pipeline packing IEEE-754 single results.

module ieee754_normalize (
    input  logic [47:0] src,
    output logic [22:0] result,
    output logic [5:0]  shifted
);
    logic [47:0] sh;

    always_comb begin
        shifted = '0;
        for (int i = 0; i < 48; i++) begin
            if (src[i]) shifted = 6'(47 - i);
        end
        sh     = src << shifted;
        result = 23'(sh >> 24);
    end
endmodule

module ieee754_norm_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_sign,
    input  logic [9:0]       req0_exp,
    input  logic [47:0]      req0_mant,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_sign,
    input  logic [9:0]       req1_exp,
    input  logic [47:0]      req1_mant,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [7:0]       out_exp,
    output logic [22:0]      out_frac,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_uflow,
    output logic             out_oflow
);
    logic             a_valid_q;
    logic             a_sign_q;
    logic             a_src_q;
    logic [9:0]       a_exp_q;
    logic [47:0]      a_mant_q;
    logic [TAG_W-1:0] a_tag_q;

    logic             b_valid_q;
    logic             b_sign_q;
    logic             b_src_q;
    logic [7:0]       b_exp_q;
    logic [22:0]      b_frac_q;
    logic [TAG_W-1:0] b_tag_q;
    logic             b_zero_q;
    logic             b_uflow_q;
    logic             b_oflow_q;

    // last_q = 1 means port 1 was granted last, so port 0 wins next tie
    logic last_q;

    logic adv_a, adv_b;
    logic gnt0, gnt1, accept;

    assign adv_b = !b_valid_q | out_ready;
    assign adv_a = !a_valid_q | adv_b;

    assign gnt0 = req0_valid & (!req1_valid | last_q);
    assign gnt1 = req1_valid & (!req0_valid | !last_q);

    assign req0_ready = adv_a & gnt0;
    assign req1_ready = adv_a & gnt1;
    assign accept     = req0_ready | req1_ready;

    logic [22:0] norm_frac;
    logic [5:0]  norm_shift;

    ieee754_normalize u_norm (
        .src     (a_mant_q),
        .result  (norm_frac),
        .shifted (norm_shift)
    );

    logic [10:0] e_d;
    logic [7:0]  exp_d;
    logic [22:0] frac_d;
    logic        zero_d, uflow_d, oflow_d;

    always_comb begin
        e_d     = {a_exp_q[9], a_exp_q} + 11'd1 - {5'd0, norm_shift};
        exp_d   = '0;
        frac_d  = '0;
        zero_d  = 1'b0;
        uflow_d = 1'b0;
        oflow_d = 1'b0;
        if (a_mant_q == '0) begin
            zero_d = 1'b1;
        end else if (e_d[10] || e_d == '0) begin
            uflow_d = 1'b1;
        end else if (e_d >= 11'd255) begin
            oflow_d = 1'b1;
            exp_d   = 8'hFF;
        end else begin
            exp_d  = e_d[7:0];
            frac_d = norm_frac;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            a_sign_q  <= 1'b0;
            a_src_q   <= 1'b0;
            a_exp_q   <= '0;
            a_mant_q  <= '0;
            a_tag_q   <= '0;
            last_q    <= 1'b1;
        end else if (adv_a) begin
            a_valid_q <= accept;
            if (accept) begin
                last_q   <= req1_ready;
                a_src_q  <= req1_ready;
                a_sign_q <= req1_ready ? req1_sign : req0_sign;
                a_exp_q  <= req1_ready ? req1_exp  : req0_exp;
                a_mant_q <= req1_ready ? req1_mant : req0_mant;
                a_tag_q  <= req1_ready ? req1_tag  : req0_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_valid_q <= 1'b0;
            b_sign_q  <= 1'b0;
            b_src_q   <= 1'b0;
            b_exp_q   <= '0;
            b_frac_q  <= '0;
            b_tag_q   <= '0;
            b_zero_q  <= 1'b0;
            b_uflow_q <= 1'b0;
            b_oflow_q <= 1'b0;
        end else if (adv_b) begin
            b_valid_q <= a_valid_q;
            if (a_valid_q) begin
                b_sign_q  <= a_sign_q;
                b_src_q   <= a_src_q;
                b_exp_q   <= exp_d;
                b_frac_q  <= frac_d;
                b_tag_q   <= a_tag_q;
                b_zero_q  <= zero_d;
                b_uflow_q <= uflow_d;
                b_oflow_q <= oflow_d;
            end
        end
    end

    assign out_valid = b_valid_q;
    assign out_sign  = b_sign_q;
    assign out_exp   = b_exp_q;
    assign out_frac  = b_frac_q;
    assign out_src   = b_src_q;
    assign out_tag   = b_tag_q;
    assign out_zero  = b_zero_q;
    assign out_uflow = b_uflow_q;
    assign out_oflow = b_oflow_q;
endmodule

// File: doc/ieee754_norm_arbiter.md
Name: ieee754_norm_arbiter

Overview:
Shares a single combinational 48-bit leading-one normalizer (ieee754_normalize: src[47:0] -> result[22:0], shifted[5:0]) between two FPU requesters, port 0 (multiplier) and port 1 (adder).
The block contains a round-robin arbiter, a two-stage valid/ready pipeline with full backpressure, and the exponent-adjust, zero, underflow and overflow packing logic.
Output is a packed IEEE-754 single (sign/exp/frac) plus the source id and the requester's tag, for the writeback mux.

Parameters:
TAG_W, 4, width of the opaque tag carried with each request and returned with its result.

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 accepted this cycle when valid&ready
req0_sign  in  1  sign
req0_exp  in  10  signed biased exponent (two's complement)
req0_mant  in  48  unnormalized significand
req0_tag  in  TAG_W  requester tag
req1_valid, req1_ready, req1_sign, req1_exp, req1_mant, req1_tag  same as port 0
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_sign  out  1  result sign
out_exp  out  8  biased exponent
out_frac  out  23  fraction (hidden bit dropped)
out_src  out  1  granted port id
out_tag  out  TAG_W  tag of granted request
out_zero  out  1  result is signed zero due to zero mantissa
out_uflow  out  1  flushed to zero due to exponent underflow
out_oflow  out  1  saturated to infinity

Behaviour:
- Value convention: value = mant * 2^(exp-127-46), i.e. a leading one at mant[46] gives exp unchanged.
- Pipeline stage A (capture register) and stage B (result register).
  - advB = !b_valid | out_ready.
  - advA = !a_valid | advB.
  - Throughput is 1/cycle. Latency is 2 cycles from accept edge to out_valid when unstalled.
- Arbitration: request accepted only when advA=1.
  - One valid: grant it.
  - Both valid: grant the port not granted last. The last-grant pointer updates only on accept.
  - reqN_ready = advA & grant==N. It depends on the valids, never on its own port's ready.
  - At most one ready is high per cycle.
- Stage A -> B: the normalizer is fed from the stage-A mant. With shift count s = shifted:
  - e = a_exp + 1 - s, computed 11-bit signed.
  - a_mant == 0: exp=0, frac=0, out_zero=1. The sign is kept.
  - else e <= 0: exp=0, frac=0, out_uflow=1. Flush; no denormals.
  - else e >= 255: exp=255, frac=0, out_oflow=1.
  - else exp=e[7:0], frac=normalizer result. Truncation, no rounding.
  - Flags are mutually exclusive, in priority order zero, uflow, oflow.
- Output registers hold stable while out_valid & !out_ready. Stage A holds while blocked.
- Reset (async, any time):
  - a_valid, b_valid, out_valid go to 0. In-flight requests are dropped.
  - The pointer is set so port 0 wins the first contention.
  - All data outputs and flags go to 0.
  - reqN_ready is 1 in the first cycle after deassertion, if valid.
- Simultaneous out_ready and new accept in the same cycle: B loads from A, A loads new. No bubble.

Test Plan:
- 1.0: port 0 only, mant=48'h4000_0000_0000, exp=127, sign=0, out_ready=1 -> 2 cycles later out_valid=1, exp=127, frac=0, src=0, flags=0.
- 3.0: port 1, mant=48'hC000_0000_0000, exp=127 -> s=0, exp=128, frac=23'h400000, src=1, tag echoed.
- Fairness: both valid every cycle, out_ready=1 -> accepts alternate 0,1,0,1 starting with 0. out_valid continuous from cycle 2. Tags in order.
- Backpressure: stream on port 0, out_ready=0 for 3 cycles -> at most 2 entries held, req0_ready=0 once full, outputs stable. After release, all results arrive in order with none lost or duplicated.
- Edge values:
  - mant=0, sign=1 -> zero=1, exp=0, sign=1.
  - mant=48'h1, exp=10 -> s=47, e=-36, uflow=1.
  - mant=48'h8000_0000_0000, exp=300 -> oflow=1, exp=255, frac=0.
- Reset mid-stream: pipeline full -> reset high for 1 cycle -> out_valid=0 immediately. With both ports valid, the first accept after release is port 0.
